fetch_unit: RTL

Instruction fetch stage of the RV32I core, directly upstream of the instruction decoder. Keeps the fetch PC, issues word requests to instruction memory over a valid/ready request channel, and buffers in-order responses in a small FIFO. Presents `{inst, inst_pc}` to the decoder with a valid/ready handshake. On a redirect from the jump/branch logic it flushes buffered and in-flight instructions.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the RV32I front end: word width, reset PC,
// the buffered fetch entry type and a PC alignment helper.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO of {pc, instr} entries with push, pop, flush and an
// occupancy count. The head is presented combinationally and reads as zero when empty.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          push,
  input  fetch_entry_t                  push_entry,
  input  logic                          pop,
  output fetch_entry_t                  head,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW-1:0]  wr_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop && (count_reg != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  assign valid = (count_reg != '0);
  assign count = count_reg;
  assign head  = valid ? mem[rd_ptr_reg] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word requests under a credit limit, buffers
// in-order responses, and discards in-flight words after a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_use;
  logic            req_fire;
  logic            rsp_live;
  logic            rsp_keep;
  logic            pop_fire;
  logic [XLEN-1:0] target_pc;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  // Credit: in-flight plus buffered words never exceed the FIFO size.
  assign in_use         = {1'b0, outstanding_reg} + {1'b0, fifo_count};
  assign imem_req_valid = !reset && (in_use < (CW + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_reg;

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign rsp_live  = imem_rsp_valid && (outstanding_reg != '0);
  assign rsp_keep  = rsp_live && (drop_cnt_reg == '0) && !redirect_valid;
  assign pop_fire  = inst_valid && inst_ready;
  assign target_pc = align_pc(redirect_pc);

  assign push_entry.pc    = rsp_pc_reg;
  assign push_entry.instr = imem_rsp_data;

  always_comb begin
    outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_live);
    fetch_pc_next    = fetch_pc_reg;
    rsp_pc_next      = rsp_pc_reg;
    drop_cnt_next    = drop_cnt_reg;
    if (redirect_valid) begin
      // Every request still in flight after this edge belongs to the old path.
      fetch_pc_next = target_pc;
      rsp_pc_next   = target_pc;
      drop_cnt_next = outstanding_next;
    end else begin
      if (req_fire) begin
        fetch_pc_next = fetch_pc_reg + XLEN'(4);
      end
      if (rsp_keep) begin
        rsp_pc_next = rsp_pc_reg + XLEN'(4);
      end
      if (rsp_live && (drop_cnt_reg != '0)) begin
        drop_cnt_next = drop_cnt_reg - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_entry(push_entry),
    .pop       (pop_fire),
    .head      (head_entry),
    .count     (fifo_count),
    .valid     (inst_valid)
  );

  assign inst    = head_entry.instr;
  assign inst_pc = head_entry.pc;

endmodule
